sd_crc_16: RTL and testbench

SD_CRC_16 -- requirements
Module: sd_crc_16

---
 rtl/sd_crc_16.sv | 46 ++++
 tb/tb_sd_crc_16.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sd_crc_16.sv
// Serial CRC-16-CCITT (x^16+x^12+x^5+1) for one SD DAT line, MSB-first.
// Define SD_CRC16_CHECK_EN to add the registered CRC_ZERO block-check flag.
module sd_crc_16 #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        BITVAL,
  input  logic        Enable,
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] CRC
`ifdef SD_CRC16_CHECK_EN
  ,
  output logic        CRC_ZERO
`endif
);

  logic        fb;
  logic [15:0] crc_next;

  always_comb begin
    fb       = BITVAL ^ CRC[15];
    crc_next = CRC;
    if (Enable) begin
      crc_next[15:13] = CRC[14:12];
      crc_next[12]    = CRC[11] ^ fb;
      crc_next[11:6]  = CRC[10:5];
      crc_next[5]     = CRC[4] ^ fb;
      crc_next[4:1]   = CRC[3:0];
      crc_next[0]     = fb;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) CRC <= INIT;
    else     CRC <= crc_next;
  end

`ifdef SD_CRC16_CHECK_EN
  // Flag is computed from the next register value so it tracks CRC exactly.
  always_ff @(posedge CLK) begin
    if (RST) CRC_ZERO <= (INIT == 16'h0000);
    else     CRC_ZERO <= (crc_next == 16'h0000);
  end
`endif

endmodule

// File: tb/tb_sd_crc_16.sv
// Randomized self-checking bench for sd_crc_16; reference is polynomial long
// division of the whole bit stream since the last reset.
module tb_sd_crc_16;

  logic        BITVAL, Enable, CLK, RST;
  logic [15:0] crc;
`ifdef SD_CRC16_CHECK_EN
  logic        crc_zero;
`endif

  sd_crc_16 dut (
    .BITVAL(BITVAL), .Enable(Enable), .CLK(CLK), .RST(RST), .CRC(crc)
`ifdef SD_CRC16_CHECK_EN
    , .CRC_ZERO(crc_zero)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit stream[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Remainder of M(x)*x^16 mod G(x), G = 0x11021, computed by long division.
  function automatic logic [15:0] ref_crc(input bit m[$]);
    logic [15:0] r;
    bit          top;
    r = 16'h0000;
    for (int i = 0; i < m.size() + 16; i++) begin
      top = r[15];
      r   = {r[14:0], (i < m.size()) ? m[i] : 1'b0};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit en, input bit b);
    RST = rst; Enable = en; BITVAL = b;
    @(posedge CLK); #1;
    if (rst) stream.delete();
    else if (en) stream.push_back(b);
  endtask

  task automatic chk_zero_flag(input string tag);
`ifdef SD_CRC16_CHECK_EN
    chk(tag, {15'b0, crc_zero}, {15'b0, (ref_crc(stream) == 16'h0000)});
`endif
  endtask

  logic [15:0] held, c;
  int          n;

  initial begin
    RST = 1'b0; Enable = 1'b0; BITVAL = 1'b0;
    @(negedge CLK);

    // reset state
    step(1, 0, 0);
    chk("reset", crc, 16'h0000);
    chk_zero_flag("reset_zero");

    // single 1 then 0
    step(0, 1, 1);
    chk("one_bit", crc, 16'h1021);
    step(0, 1, 0);
    chk("two_bits", crc, 16'h2042);
    chk("two_bits_model", crc, ref_crc(stream));

    // 512 bytes of 0xFF
    step(1, 0, 0);
    for (int i = 0; i < 4096; i++) step(0, 1, 1);
    chk("ff_block", crc, 16'h7FA1);
    chk("ff_block_model", crc, ref_crc(stream));
    chk_zero_flag("ff_block_zero");

    // zeros never move the register
    step(1, 0, 0);
    n = $urandom_range(1, 200);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0);
      chk("zeros", crc, 16'h0000);
    end

    // RST held high with random other inputs
    for (int i = 0; i < 8; i++) begin
      step(1, 1'($urandom), 1'($urandom));
      chk("rst_hold", crc, 16'h0000);
    end

    // short random streams with random enable, checked every cycle
    for (int t = 0; t < 20; t++) begin
      step(1, 0, 0);
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) begin
        step(0, 1'($urandom), 1'($urandom));
        chk("rand_stream", crc, ref_crc(stream));
        chk_zero_flag("rand_zero");
      end
    end

    // enable gap mid-stream
    step(1, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 1'($urandom));
    held = ref_crc(stream);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i[0]);
      chk("gap_hold", crc, held);
    end
    for (int i = 0; i < 300; i++) step(0, 1, 1'($urandom));
    chk("gap_resume", crc, ref_crc(stream));

    // random block with its own CRC appended
    step(1, 0, 0);
    for (int i = 0; i < 4096; i++) step(0, 1, 1'($urandom));
    c = ref_crc(stream);
    chk("blk_crc", crc, c);
    for (int i = 15; i >= 0; i--) step(0, 1, c[i]);
    chk("blk_append", crc, 16'h0000);
    chk_zero_flag("blk_append_zero");
`ifdef SD_CRC16_CHECK_EN
    chk("blk_zero_flag", {15'b0, crc_zero}, 16'h0001);
`endif

    // reset wins over enable mid-stream
    for (int i = 0; i < 37; i++) step(0, 1, 1'($urandom));
    step(1, 1, 1);
    chk("rst_prio", crc, 16'h0000);
    step(0, 1, 1);
    chk("after_rst", crc, 16'h1021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
